// File: rtl/serial_pkg.sv
// Shared definitions for the serial front-end blocks.
// Holds the PISO state encoding and the default serial word width.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int SER_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/piso_shift_reg.sv
// Load/shift register for the PISO serializer.
// Ports:
//   clk, rst  - clock and asynchronous active-low reset
//   load      - capture din (takes priority over shift)
//   shift     - advance one bit toward the output end
//   din       - parallel word
//   nxt_bit   - the bit that will sit at the output end after this edge;
//               the top registers it so ser_data lines up with the state
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             nxt_bit
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        end
    end

    // Look ahead one edge: the bit at the output end after the pending update.
    always_comb begin
        if (load) begin
            nxt_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
        end else if (shift) begin
            nxt_bit = MSB_FIRST ? sr[WIDTH-2] : sr[1];
        end else begin
            nxt_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        end
    end

endmodule : piso_shift_reg

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// Accepts WIDTH-bit words over valid/ready and emits one bit per clock,
// with an optional GAP-cycle idle period after each word.
// Ports:
//   clk, rst   - clock and asynchronous active-low reset
//   in_data    - parallel word, captured on acceptance only
//   in_valid   - upstream word available
//   in_ready   - word can be accepted this cycle (no in_valid dependency)
//   ser_data   - serial bit, IDLE_LEVEL whenever ser_valid is low
//   ser_valid  - ser_data carries a payload bit
//   ser_last   - final bit of the word
//   busy       - in SHIFT or GAP
module piso_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH      = SER_WIDTH,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter bit   MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          accept, shift, nxt_bit;
    logic          ser_data_n, ser_valid_n, ser_last_n, busy_n;

    // Back-to-back acceptance on the last bit only exists without a gap.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            if (state == ST_IDLE) begin
                in_ready = 1'b1;
            end else if (GAP == 0 && state == ST_SHIFT && cnt == CNT_LAST) begin
                in_ready = 1'b1;
            end
        end
    end

    assign accept = in_valid & in_ready;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .shift   (shift),
        .din     (in_data),
        .nxt_bit (nxt_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gcnt  <= gcnt_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        shift   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SHIFT;
                    cnt_n   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    if (accept) begin
                        state_n = ST_SHIFT;
                        cnt_n   = '0;
                    end else if (GAP > 0) begin
                        state_n = ST_GAP;
                        gcnt_n  = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    shift = 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output logic: computed from the next state so the registered
    // outputs describe the cycle the FSM is about to enter.
    always_comb begin
        ser_valid_n = (state_n == ST_SHIFT);
        ser_last_n  = ser_valid_n && (cnt_n == CNT_LAST);
        busy_n      = (state_n != ST_IDLE);
        ser_data_n  = ser_valid_n ? nxt_bit : IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_data  <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ser_data  <= ser_data_n;
            ser_valid <= ser_valid_n;
            ser_last  <= ser_last_n;
            busy      <= busy_n;
        end
    end

endmodule : piso_serializer

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the serial Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock.
- Outputs: the serial bit, a bit-valid strobe and a last-bit flag, which together drive the detector's data input.
- An optional inter-word gap drives an idle level between words.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
GAP, 0, idle cycles inserted after each word; 0 means back-to-back words are allowed
IDLE_LEVEL, 1'b0, value driven on ser_data whenever no bit is valid
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first, 0 = bit 0 first

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
in_data  input  WIDTH  parallel word; sampled only at acceptance
in_valid  input  1  upstream has a word on in_data
in_ready  output  1  block can accept a word this cycle
ser_data  output  1  serial bit to the detector
ser_valid  output  1  ser_data holds a real payload bit this cycle
ser_last  output  1  high on the final bit of a word
busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0, gap counter=0.
- Output reset values: ser_data=IDLE_LEVEL, ser_valid=0, ser_last=0, busy=0.
- in_ready is forced to 0 while rst=0.
- ser_data, ser_valid, ser_last and busy are registered. in_ready is combinational from state and counters only; no in_valid-to-in_ready path.
- Acceptance: a word is accepted on a rising edge where in_valid=1 and in_ready=1. in_data is captured into the shift register on that edge; later changes to in_data are ignored.
- Latency: the first bit appears on ser_data, with ser_valid=1, in the cycle immediately after the acceptance edge.
- IDLE state:
  - in_ready=1, ser_valid=0, ser_data=IDLE_LEVEL.
  - On acceptance, go to SHIFT with bit counter=0.
- SHIFT state:
  - Emits WIDTH consecutive bits, one per cycle, with ser_valid=1 on every one of them.
  - The bit counter increments each cycle; ser_last=1 only when counter=WIDTH-1.
  - The counter is $clog2(WIDTH) bits wide and never wraps inside a word.
- End of word with GAP=0:
  - in_ready=1 during the last-bit cycle.
  - If in_valid=1 in that cycle, the new word is accepted and its first bit follows with no bubble: ser_valid stays continuously high and the state stays SHIFT.
  - Otherwise the next state is IDLE.
- End of word with GAP>0:
  - in_ready=0 throughout SHIFT. The next state is GAP.
- GAP state:
  - Lasts exactly GAP cycles, with ser_valid=0, ser_last=0, ser_data=IDLE_LEVEL, in_ready=0, busy=1.
  - Then go to IDLE, where in_ready=1 in the following cycle.
- Bit order: MSB_FIRST=1 shifts left and emits the MSB. MSB_FIRST=0 shifts right and emits the LSB.
- Invalid-bit guarantee: ser_data equals IDLE_LEVEL whenever ser_valid=0. The downstream detector then sees a defined level between words.
- Reset mid-operation: the in-flight word is discarded and all outputs return to their reset values asynchronously. After release, the block behaves as from power-up; no partial word is resumed.
- in_valid is ignored whenever in_ready=0; holding it high does not queue a word.

Decomposition:
- Shared package serial_pkg holds:
  - the state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2);
  - the default width constant SER_WIDTH=8.
- The gap counter and bit counter stay inline. A single sub-module is natural for the SHIFT datapath: piso_shift_reg (load/shift/direction), instantiated once.

Test Plan:
- WIDTH=8, MSB_FIRST=1, GAP=0; accept 8'hA5 -> from the next cycle ser_data = 1,0,1,0,0,1,0,1.
  - ser_valid high for exactly 8 cycles; ser_last only on the 8th; busy drops the cycle after; ser_data=0 afterwards.
- GAP=0, in_valid held with 8'hA5 then 8'h3C -> 16 contiguous ser_valid cycles with bits 10100101 00111100.
  - in_ready high only in IDLE and on bit 8 of the first word; ser_last high on cycles 8 and 16.
- GAP=2, two words 8'hFF then 8'h01 -> after the first word's 8 bits, exactly 2 cycles with ser_valid=0, in_ready=0, ser_data=IDLE_LEVEL.
  - in_ready=1 on the next cycle; the second word starts one cycle after its acceptance.
- MSB_FIRST=0, accept 8'h96 -> bits emitted 0,1,1,0,1,0,0,1.
- Accept 8'hA5, pull rst low after 3 bits -> outputs immediately become 0/IDLE_LEVEL and in_ready=0.
  - After release, accept 8'h0F -> clean output 0,0,0,0,1,1,1,1 with no residue of 8'hA5.
- Accept 8'h90, then change in_data to 8'hFF the next cycle -> serial output is still 1,0,0,1,0,0,0,0.
  - When fed to the downstream detector, its output matches running it directly with that bit sequence.
